stream_pack: RTL and testbench

Packs a stream of narrow samples into wide words, RATIO samples per word, and presents the result through a registered valid/ready output. It sits directly upstream of the team's skid-buffer stage (`stream_buf`) on the sample path, turning per-sample ADC/decimator output into bus-width words for the host transfer path. A flush input lets the producer close a partially filled word at a block boundary.

---
 rtl/stream_pack.sv | 93 +++++++++
 tb/tb_stream_pack.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_pack.sv
// Packs RATIO narrow samples into one wide word behind a registered valid/ready output.
// A flush closes a partial word; unused upper lanes are always zero.
module stream_pack #(
   parameter  int IN_WIDTH = 8,
   parameter  int RATIO    = 4,
   localparam int LW       = $clog2(RATIO + 1)
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [IN_WIDTH-1:0]       i_data,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic                      i_flush,
   output logic [IN_WIDTH*RATIO-1:0] o_data,
   output logic [LW-1:0]             o_lanes,
   output logic                      o_valid,
   input  logic                      i_ready
);

   logic [IN_WIDTH-1:0]       acc [RATIO-1];
   logic [IN_WIDTH-1:0]       lane_next [RATIO];
   logic [IN_WIDTH*RATIO-1:0] word_next;
   logic [LW-1:0]             cnt;
   logic [LW-1:0]             n;
   logic                      pend;
   logic                      run;
   logic                      out_free;
   logic                      acc_in;
   logic                      full;
   logic                      part;
   logic                      load;
   logic                      hold;

   // run keeps o_ready low during reset and releases it one edge later
   assign out_free = !o_valid || i_ready;
   assign o_ready  = run && !pend && ((cnt != LW'(RATIO - 1)) || out_free);
   assign acc_in   = i_valid && o_ready;
   assign n        = cnt + LW'(acc_in);
   assign full     = acc_in && (cnt == LW'(RATIO - 1));
   assign part     = (i_flush || pend) && (n != '0) && !full;
   assign load     = full || (part && out_free);
   assign hold     = part && !out_free;

   // Lanes below cnt come from acc, lane cnt takes a same-cycle sample, the rest are zero
   for (genvar k = 0; k < RATIO; k++) begin : g_lane
      if (k < RATIO - 1) begin : g_acc
         assign lane_next[k] = (LW'(k) < cnt) ? acc[k] :
                               (acc_in && (cnt == LW'(k))) ? i_data : '0;
      end else begin : g_top
         assign lane_next[k] = (acc_in && (cnt == LW'(k))) ? i_data : '0;
      end
      assign word_next[k*IN_WIDTH +: IN_WIDTH] = lane_next[k];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run     <= 1'b0;
         o_data  <= '0;
         o_lanes <= '0;
         o_valid <= 1'b0;
         cnt     <= '0;
         pend    <= 1'b0;
         for (int k = 0; k < RATIO - 1; k++) begin
            acc[k] <= '0;
         end
      end else begin
         run <= 1'b1;
         if (load) begin
            o_data  <= word_next;
            o_lanes <= n;
            o_valid <= 1'b1;
            cnt     <= '0;
            pend    <= 1'b0;
         end else begin
            if (i_ready) begin
               o_valid <= 1'b0;
            end
            if (acc_in) begin
               cnt <= n;
            end
            if (hold) begin
               pend <= 1'b1;
            end
         end
         for (int k = 0; k < RATIO - 1; k++) begin
            if (acc_in && !load && (cnt == LW'(k))) begin
               acc[k] <= i_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_pack.sv
// Scoreboard bench for stream_pack: expected words are queued as stimulus is driven
// and compared whenever the packer hands a word downstream.
module tb_stream_pack;

   localparam int IN_WIDTH = 8;
   localparam int RATIO    = 4;
   localparam int LW       = $clog2(RATIO + 1);

   typedef struct packed {
      logic [IN_WIDTH*RATIO-1:0] data;
      logic [LW-1:0]             lanes;
   } word_t;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic [IN_WIDTH-1:0]       sample = '0;
   logic                      sample_valid = 1'b0;
   logic                      ready_up;
   logic                      flush = 1'b0;
   logic [IN_WIDTH*RATIO-1:0] word;
   logic [LW-1:0]             lanes;
   logic                      word_valid;
   logic                      ready_down = 1'b1;

   word_t exp_q[$];
   word_t mon_exp;
   int    checks = 0;
   int    failures = 0;
   int    stalls = 0;
   int    unstable = 0;
   int    ready_hi = 0;
   int    idx = 0;
   logic  track_stall = 1'b0;
   logic  held_prev = 1'b0;
   logic  took;
   logic [IN_WIDTH*RATIO-1:0] held_word = '0;
   logic [LW-1:0]             held_lanes = '0;

   stream_pack #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_data  (sample),
      .i_valid (sample_valid),
      .o_ready (ready_up),
      .i_flush (flush),
      .o_data  (word),
      .o_lanes (lanes),
      .o_valid (word_valid),
      .i_ready (ready_down)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic expect_word(input logic [IN_WIDTH*RATIO-1:0] d, input int l);
      word_t w;
      w.data  = d;
      w.lanes = LW'(l);
      exp_q.push_back(w);
   endtask

   // Presents one sample until the DUT takes it; inputs change 1 time unit after the edge
   task automatic apply_stimulus(input logic [IN_WIDTH-1:0] d, input logic f);
      logic done;
      done         = 1'b0;
      sample       = d;
      sample_valid = 1'b1;
      flush        = f;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (ready_up) done = 1'b1;
      end
      check_output("sample_accepted", 64'(done), 64'd1);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      flush        = 1'b0;
   endtask

   task automatic flush_only();
      sample_valid = 1'b0;
      flush        = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   // Every downstream transfer must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst_n && word_valid && ready_down) begin
         check_output("word_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            check_output("word_data", 64'(word), 64'(mon_exp.data));
            check_output("word_lanes", 64'(lanes), 64'(mon_exp.lanes));
         end
      end
   end

   always @(negedge clk) begin
      if (track_stall && !ready_up) stalls <= stalls + 1;
      if (rst_n && held_prev && (!word_valid || word !== held_word || lanes !== held_lanes))
         unstable <= unstable + 1;
      held_prev  <= rst_n && word_valid && !ready_down;
      held_word  <= word;
      held_lanes <= lanes;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset values
      idle(3);
      check_output("rst_valid", 64'(word_valid), 64'd0);
      check_output("rst_data", 64'(word), 64'd0);
      check_output("rst_lanes", 64'(lanes), 64'd0);
      check_output("rst_ready", 64'(ready_up), 64'd0);
      rst_n = 1'b1;
      idle(1);
      check_output("ready_after_rst", 64'(ready_up), 64'd1);

      // Full-rate packing
      expect_word(32'h04030201, 4);
      expect_word(32'h08070605, 4);
      track_stall = 1'b1;
      for (int i = 1; i <= 8; i++) apply_stimulus(8'(i), 1'b0);
      track_stall = 1'b0;
      idle(4);
      check_output("full_rate_stalls", 64'(stalls), 64'd0);
      check_output("full_rate_left", 64'(exp_q.size()), 64'd0);

      // Backpressure: 10 samples offered against a stalled output
      ready_down = 1'b0;
      idx = 0;
      for (int c = 0; c < 20; c++) begin
         sample_valid = (idx < 10);
         sample       = 8'(16 + idx);
         @(negedge clk);
         took = ready_up && sample_valid;
         @(posedge clk);
         #1;
         if (took) idx++;
      end
      sample_valid = 1'b0;
      check_output("bp_accepted", 64'(idx), 64'd7);
      check_output("bp_ready_low", 64'(ready_up), 64'd0);
      check_output("bp_held_data", 64'(word), 64'h13121110);
      check_output("bp_held_lanes", 64'(lanes), 64'd4);
      expect_word(32'h13121110, 4);
      expect_word(32'h17161514, 4);
      expect_word(32'h00001918, 2);
      ready_down = 1'b1;
      for (int i = 7; i < 10; i++) apply_stimulus(8'(16 + i), 1'b0);
      flush_only();
      idle(4);
      check_output("bp_left", 64'(exp_q.size()), 64'd0);

      // Partial flush, alone and with a same-cycle sample
      expect_word(32'h0000BBAA, 2);
      apply_stimulus(8'hAA, 1'b0);
      apply_stimulus(8'hBB, 1'b0);
      flush_only();
      idle(3);
      expect_word(32'h00CCBBAA, 3);
      apply_stimulus(8'hAA, 1'b0);
      apply_stimulus(8'hBB, 1'b0);
      apply_stimulus(8'hCC, 1'b1);
      idle(3);
      check_output("partial_left", 64'(exp_q.size()), 64'd0);

      // Flush on an empty packer, then flush with the last lane
      flush_only();
      idle(3);
      check_output("empty_flush_valid", 64'(word_valid), 64'd0);
      expect_word(32'h44332211, 4);
      apply_stimulus(8'h11, 1'b0);
      apply_stimulus(8'h22, 1'b0);
      apply_stimulus(8'h33, 1'b0);
      apply_stimulus(8'h44, 1'b1);
      idle(4);
      check_output("full_flush_left", 64'(exp_q.size()), 64'd0);
      check_output("full_flush_valid", 64'(word_valid), 64'd0);

      // Pending flush behind a held word
      ready_down = 1'b0;
      expect_word(32'h54535251, 4);
      for (int i = 0; i < 4; i++) apply_stimulus(8'(8'h51 + i), 1'b0);
      apply_stimulus(8'h61, 1'b0);
      apply_stimulus(8'h62, 1'b0);
      flush_only();
      ready_hi = 0;
      repeat (5) begin
         @(negedge clk);
         if (ready_up) ready_hi++;
      end
      @(posedge clk);
      #1;
      check_output("pend_ready_low", 64'(ready_hi), 64'd0);
      check_output("pend_held_data", 64'(word), 64'h54535251);
      expect_word(32'h00006261, 2);
      ready_down = 1'b1;
      idle(4);
      check_output("pend_left", 64'(exp_q.size()), 64'd0);
      check_output("pend_ready_back", 64'(ready_up), 64'd1);

      // Reset in the middle of a word with an output word held
      ready_down = 1'b0;
      for (int i = 0; i < 4; i++) apply_stimulus(8'(8'h81 + i), 1'b0);
      for (int i = 0; i < 3; i++) apply_stimulus(8'(8'h71 + i), 1'b0);
      check_output("pre_rst_valid", 64'(word_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check_output("mid_rst_valid", 64'(word_valid), 64'd0);
      check_output("mid_rst_data", 64'(word), 64'd0);
      check_output("mid_rst_lanes", 64'(lanes), 64'd0);
      check_output("mid_rst_ready", 64'(ready_up), 64'd0);
      idle(2);
      rst_n      = 1'b1;
      ready_down = 1'b1;
      idle(1);
      expect_word(32'h94939291, 4);
      for (int i = 0; i < 4; i++) apply_stimulus(8'(8'h91 + i), 1'b0);
      idle(4);
      check_output("post_rst_left", 64'(exp_q.size()), 64'd0);
      check_output("output_stability", 64'(unstable), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
